garbage_insert: RTL
===================

GARBAGE_INSERT -- requirements
Module: garbage_insert

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning board columns.
REQ-002 SHALL have parameter HEIGHT, default 20, meaning board rows.
REQ-003 SHALL have parameter CELL_W, default 3, meaning bits per cell; 0 = empty, 1..7 = brick type.
REQ-004 SHALL have parameter GARBAGE, default 7, meaning the cell code written into inserted cells.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-007 SHALL have port start  input  1  meaning a one-cycle request to insert rows.
REQ-008 SHALL have port num_rows  input  3  meaning the number of rows to insert, 0..7.
REQ-009 SHALL have port seed  input  8  meaning the LFSR load value, sampled only at reset release.
REQ-010 SHALL have port cur_board  input  WIDTH*HEIGHT*CELL_W  meaning the source board; cell (x,y) occupies bits [(y*WIDTH+x)*CELL_W +: CELL_W], with y=0 the bottom row.
REQ-011 SHALL have port nxt_board  output  WIDTH*HEIGHT*CELL_W  meaning the result board, in the same layout as cur_board.
REQ-012 SHALL have port busy  output  1  meaning an insertion is in progress.
REQ-013 SHALL have port done  output  1  meaning a one-cycle pulse that nxt_board is final.
REQ-014 SHALL have port top_out  output  1  meaning a non-empty row was pushed off the top during the last operation.

Function
REQ-015 SHALL implement states IDLE, SHIFT and DONE.
REQ-016 In IDLE with start=1, SHALL latch cur_board into the working board and num_rows into the row counter, clear top_out, and go to SHIFT (num_rows>0) or DONE (num_rows=0).
REQ-017 In SHIFT, each cycle SHALL move every row y to y+1, discard row HEIGHT-1, load row 0 with the garbage row, decrement the counter, and advance the LFSR once.
REQ-018 The garbage row SHALL hold GARBAGE in every column except hole column h = lfsr mod WIDTH, which is 0.
REQ-019 If the discarded row HEIGHT-1 holds any non-zero cell during a SHIFT cycle, SHALL set top_out; top_out is sticky until the next accepted start.
REQ-020 SHALL go from SHIFT to DONE on the cycle the counter reaches 0.
REQ-021 In DONE, SHALL assert done for exactly one cycle and then return to IDLE.
REQ-022 Latency from the start edge to done high SHALL be num_rows+1 cycles.
REQ-023 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 cur_board changes after the start cycle SHALL NOT affect the result.
REQ-026 nxt_board SHALL show the working board at all times and hold its value in IDLE until the next operation.
REQ-027 The LFSR SHALL be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting left with the feedback bit into bit 0.
REQ-028 A seed of 0 SHALL load 8'h01 so the LFSR never locks up.
REQ-029 When num_rows >= HEIGHT, SHALL still perform exactly num_rows shifts; rows beyond HEIGHT are pure garbage.

Reset
REQ-030 On rst=1, SHALL immediately set state IDLE, nxt_board 0, busy 0, done 0, top_out 0, counter 0, and LFSR to seed (or 8'h01 if seed=0).
REQ-031 When rst is asserted mid-SHIFT, SHALL abort the operation with no done pulse; the partial board is lost.

Verification
REQ-032 Empty board, seed=8'h01, num_rows=1 -> done at cycle 2; row 0 = GARBAGE in all columns except column 1 (lfsr 8'h01 mod 10); all other rows 0; top_out=0.
REQ-033 Row 0 all 1s, num_rows=3 -> original row moves to y=3; rows 0..2 are garbage with holes from three successive LFSR values; done at cycle 4.
REQ-034 Row HEIGHT-1 holds one non-zero cell, num_rows=1 -> top_out=1, held until the next start.
REQ-035 num_rows=0 -> done the cycle after start; nxt_board equals cur_board; busy high for one cycle.
REQ-036 start pulsed again mid-SHIFT, and cur_board changed -> no effect on the result or the timing.
REQ-037 rst asserted during SHIFT of num_rows=5 -> outputs zero asynchronously; no done pulse; a new start after release works normally.

Source files
------------

// File: rtl/garbage_insert.sv
// Garbage row insertion for a falling-brick board.
// Pushes num_rows LFSR-holed garbage rows in from the bottom, one per cycle.
module garbage_insert #(
  parameter int WIDTH   = 10,
  parameter int HEIGHT  = 20,
  parameter int CELL_W  = 3,
  parameter int GARBAGE = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [2:0]                     num_rows,
  input  logic [7:0]                     seed,
  input  logic [WIDTH*HEIGHT*CELL_W-1:0] cur_board,
  output logic [WIDTH*HEIGHT*CELL_W-1:0] nxt_board,
  output logic                           busy,
  output logic                           done,
  output logic                           top_out
);

  localparam int ROW_W   = WIDTH * CELL_W;
  localparam int BOARD_W = ROW_W * HEIGHT;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [BOARD_W-1:0] board;
  logic [2:0]         cnt;
  logic [7:0]         lfsr;
  logic [7:0]         hole;
  logic               fb;
  logic               top_hit;
  logic [ROW_W-1:0]   garbage_row;

  assign hole      = lfsr % 8'(WIDTH);
  assign fb        = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign top_hit   = |board[BOARD_W-1 -: ROW_W];
  assign nxt_board = board;

  // Build the incoming bottom row: solid garbage with one empty hole.
  always_comb begin
    garbage_row = '0;
    for (int x = 0; x < WIDTH; x++) begin
      if (8'(x) != hole)
        garbage_row[x*CELL_W +: CELL_W] = CELL_W'(GARBAGE);
    end
  end

  // Control FSM with working board, row counter, LFSR and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      board   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      top_out <= 1'b0;
      lfsr    <= (seed == 8'h00) ? 8'h01 : seed;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            board   <= cur_board;
            cnt     <= num_rows;
            top_out <= 1'b0;
            busy    <= 1'b1;
            state   <= (num_rows == 3'd0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          board <= {board[BOARD_W-ROW_W-1:0], garbage_row};
          cnt   <= cnt - 3'd1;
          lfsr  <= {lfsr[6:0], fb};
          if (top_hit)
            top_out <= 1'b1;
          if (cnt == 3'd1)
            state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
